fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline and the producer side of the IF/ID register.
- Owns the PC and drives PCPlus4F, RD_ROM and CLR into IF/ID.
- Fetches from an instruction ROM over a req/ack handshake with variable latency.
- Applies jump and branch redirects from the decode stage, honours StallF, and squashes wrong-path or missing fetches by asserting CLR, which makes IF/ID load its bubble.

---
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-ROM request/acknowledge bus between the fetch stage and the ROM.
// The fetch stage is the master. It holds rom_req and rom_addr until rom_ack.
// rom_rdata is only meaningful in a cycle where rom_ack is high.
interface fetch_unit_if;
   logic        rom_req;
   logic [31:0] rom_addr;
   logic        rom_ack;
   logic [31:0] rom_rdata;

   modport master (output rom_req, output rom_addr, input rom_ack, input rom_rdata);
   modport slave  (input rom_req, input rom_addr, output rom_ack, output rom_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and feeds the IF/ID register.
// A ROM request, once issued, is held until it is acknowledged.
// A redirect that arrives while a request is outstanding is parked in DRAIN.
// The stale word is then discarded and the PC is moved to the parked target.
// A stall on the ack cycle captures the word into HOLD, so the ROM is not re-read.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                StallF,
   input  logic                PCSrcD,
   input  logic [31:0]         PCBranchD,
   input  logic                JumpD,
   input  logic [31:0]         PCJumpD,
   fetch_unit_if.master        rom,
   output logic [31:0]         PCF,
   output logic [31:0]         PCPlus4F,
   output logic [31:0]         RD_ROM,
   output logic                CLR,
   output logic                FetchBusy
);

   typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] pend_q, pend_d;

   logic        redirect;
   logic [31:0] tgt_raw, target;
   logic        req, clr, busy;
   logic [31:0] rd;

   // Decode-stage redirect is only honoured when fetch is not stalled.
   // Jump wins over branch.
   assign redirect = !StallF && (JumpD || PCSrcD);
   assign tgt_raw  = JumpD ? PCJumpD : PCBranchD;
   assign target   = tgt_raw & ~32'd3;

   // State, PC, hold buffer and parked target registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         buf_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state and IF/ID-facing outputs.
   // The default is a bubble, with fetch busy.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      pend_d  = pend_q;
      req     = 1'b0;
      rd      = '0;
      clr     = 1'b1;
      busy    = 1'b1;
      case (state_q)
         FETCH: begin
            req = 1'b1;
            if (rom.rom_ack) begin
               busy = 1'b0;
               if (redirect) begin
                  pc_d = target;
               end else if (StallF) begin
                  buf_d   = rom.rom_rdata;
                  rd      = rom.rom_rdata;
                  clr     = 1'b0;
                  state_d = HOLD;
               end else begin
                  rd   = rom.rom_rdata;
                  clr  = 1'b0;
                  pc_d = pc_q + 32'd4;
               end
            end else if (redirect) begin
               pend_d  = target;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Keep the old request alive. A newer redirect replaces the parked one.
            req = 1'b1;
            if (redirect) pend_d = target;
            if (rom.rom_ack) begin
               pc_d    = redirect ? target : pend_q;
               state_d = FETCH;
            end
         end
         HOLD: begin
            busy = 1'b0;
            rd   = buf_q;
            clr  = 1'b0;
            if (!StallF) begin
               state_d = FETCH;
               if (redirect) begin
                  pc_d = target;
                  rd   = '0;
                  clr  = 1'b1;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
         end
         default: state_d = FETCH;
      endcase
      // While reset is held, no request goes out and IF/ID sees a bubble.
      if (rst) begin
         req = 1'b0;
         rd  = '0;
         clr = 1'b1;
      end
   end

   assign rom.rom_req  = req;
   assign rom.rom_addr = pc_q;
   assign PCF          = pc_q;
   assign PCPlus4F     = pc_q + 32'd4;
   assign RD_ROM       = rd;
   assign CLR          = clr;
   assign FetchBusy    = busy;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit.
// The behavioural ROM has a programmable latency; lat=1 acks in the request cycle.
// Each instruction that IF/ID should accept goes into a queue as {PC, word}.
// A monitor pops the queue on every cycle where CLR=0 and StallF=0, then compares.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        StallF, PCSrcD, JumpD;
   logic [31:0] PCBranchD, PCJumpD;
   logic [31:0] PCF, PCPlus4F, RD_ROM;
   logic        CLR, FetchBusy;

   int tests = 0;
   int fails = 0;
   int lat;
   int cnt;

   typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
   exp_t sb[$];

   fetch_unit_if rom_bus();

   fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
      .clk(clk), .rst(rst), .StallF(StallF), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
      .JumpD(JumpD), .PCJumpD(PCJumpD), .rom(rom_bus.master), .PCF(PCF),
      .PCPlus4F(PCPlus4F), .RD_ROM(RD_ROM), .CLR(CLR), .FetchBusy(FetchBusy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] w(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   // ROM model: count the cycles that the current request has been waiting.
   always @(posedge clk or posedge rst) begin
      if (rst) cnt <= 0;
      else if (rom_bus.rom_req) cnt <= rom_bus.rom_ack ? 0 : cnt + 1;
   end
   assign rom_bus.rom_ack   = rom_bus.rom_req && (cnt >= lat - 1);
   assign rom_bus.rom_rdata = rom_bus.rom_ack ? w(rom_bus.rom_addr) : 32'hDEAD_DEAD;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: IF/ID accepts a word whenever it is not a bubble and fetch is not stalled.
   always @(negedge clk) begin
      if (!rst && !CLR && !StallF) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_unexpected: got RD_ROM %h at PCF %h expected no instruction", RD_ROM, PCF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_word", RD_ROM, e.word);
            chk("sb_pc", PCF, e.pc);
         end
      end
   end

   task automatic drv(input logic s, input logic src, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
      StallF = s; PCSrcD = src; PCBranchD = bt; JumpD = j; PCJumpD = jt;
   endtask

   task automatic push(input logic [31:0] pc);
      exp_t e;
      e.pc = pc; e.word = w(pc);
      sb.push_back(e);
   endtask

   // Check one cycle's outputs at the falling edge, then advance to just after the rising edge.
   task automatic cy(input string tag, input logic [31:0] pc, input logic clr,
                     input logic [31:0] rd, input logic busy, input logic req);
      logic [31:0] p4;
      p4 = pc + 32'd4;
      @(negedge clk);
      chk({tag, "_pc"}, PCF, pc);
      chk({tag, "_p4"}, PCPlus4F, p4);
      chk({tag, "_addr"}, rom_bus.rom_addr, pc);
      chk({tag, "_clr"}, {31'd0, CLR}, {31'd0, clr});
      chk({tag, "_rd"}, RD_ROM, rd);
      chk({tag, "_busy"}, {31'd0, FetchBusy}, {31'd0, busy});
      chk({tag, "_req"}, {31'd0, rom_bus.rom_req}, {31'd0, req});
      @(posedge clk); #1;
   endtask

   task automatic rstchk(input string tag);
      chk({tag, "_pc"}, PCF, 32'h3000);
      chk({tag, "_clr"}, {31'd0, CLR}, 32'd1);
      chk({tag, "_rd"}, RD_ROM, 32'd0);
      chk({tag, "_req"}, {31'd0, rom_bus.rom_req}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; lat = 3; drv(0, 0, 0, 0, 0);
      #12;
      rstchk("reset");
      chk("reset_p4", PCPlus4F, 32'h3004);
      @(posedge clk); #1; rst = 1'b0;

      // A request with 3-cycle latency at the reset PC.
      cy("lat_w1", 32'h3000, 1, 0, 1, 1);
      cy("lat_w2", 32'h3000, 1, 0, 1, 1);
      push(32'h3000); cy("lat_ack", 32'h3000, 0, w(32'h3000), 0, 1);

      // Zero-latency ROM gives back-to-back instructions.
      lat = 1;
      push(32'h3004); cy("seq0", 32'h3004, 0, w(32'h3004), 0, 1);
      push(32'h3008); cy("seq1", 32'h3008, 0, w(32'h3008), 0, 1);

      // Stall on the ack of 0x300C; redirects during the stall must be ignored.
      drv(1, 0, 0, 0, 0);                 cy("stl_ack", 32'h300C, 0, w(32'h300C), 0, 1);
      drv(1, 1, 32'h7000, 0, 0);          cy("stl_h1", 32'h300C, 0, w(32'h300C), 0, 0);
      drv(1, 0, 0, 1, 32'h7800);          cy("stl_h2", 32'h300C, 0, w(32'h300C), 0, 0);
      drv(0, 0, 0, 0, 0); push(32'h300C); cy("stl_rel", 32'h300C, 0, w(32'h300C), 0, 0);

      // Jump has priority over branch, and the branch target has its low bits cleared.
      drv(0, 1, 32'h5000, 1, 32'h4000);   cy("jmp", 32'h3010, 1, 0, 0, 1);
      drv(0, 0, 0, 0, 0); push(32'h4000); cy("jmp_tgt", 32'h4000, 0, w(32'h4000), 0, 1);
      drv(0, 1, 32'h5003, 0, 0);          cy("br", 32'h4004, 1, 0, 0, 1);
      drv(0, 0, 0, 0, 0); push(32'h5000); cy("br_tgt", 32'h5000, 0, w(32'h5000), 0, 1);

      // Redirect while a 4-cycle request is outstanding. A stalled jump in DRAIN is ignored.
      lat = 4;
      drv(0, 1, 32'h6000, 0, 0);          cy("dr_issue", 32'h5004, 1, 0, 1, 1);
      drv(0, 0, 0, 0, 0);                 cy("dr_w1", 32'h5004, 1, 0, 1, 1);
      drv(1, 0, 0, 1, 32'h9000);          cy("dr_stl", 32'h5004, 1, 0, 1, 1);
      drv(0, 0, 0, 0, 0);                 cy("dr_ack", 32'h5004, 1, 0, 1, 1);
      lat = 1;
      push(32'h6000);                     cy("dr_tgt", 32'h6000, 0, w(32'h6000), 0, 1);

      // The PC wraps from the top word to 0, and a jump target has its low bits cleared.
      drv(0, 0, 0, 1, 32'hFFFF_FFFF);     cy("wr_jmp", 32'h6004, 1, 0, 0, 1);
      drv(0, 0, 0, 0, 0); push(32'hFFFF_FFFC);
      cy("wr_top", 32'hFFFF_FFFC, 0, w(32'hFFFF_FFFC), 0, 1);

      // Asynchronous reset in the middle of DRAIN.
      lat = 5;
      drv(0, 1, 32'h100, 0, 0);           cy("g_issue", 32'h0, 1, 0, 1, 1);
      drv(0, 0, 0, 0, 0);
      #2 rst = 1'b1; #1;
      rstchk("rst_drain");
      @(posedge clk); #1; rst = 1'b0; lat = 1;
      push(32'h3000);                     cy("g_rel", 32'h3000, 0, w(32'h3000), 0, 1);

      // Asynchronous reset in the middle of HOLD.
      drv(1, 0, 0, 0, 0);                 cy("h_ack", 32'h3004, 0, w(32'h3004), 0, 1);
      chk("h_pre_rd", RD_ROM, w(32'h3004));
      #2 rst = 1'b1; #1;
      rstchk("rst_hold");
      @(posedge clk); #1; rst = 1'b0; drv(0, 0, 0, 0, 0);
      push(32'h3000);                     cy("h_rel", 32'h3000, 0, w(32'h3000), 0, 1);

      // Park the stage under a stall, then make sure every expected word was consumed.
      drv(1, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
